// File: rtl/md5_crack_pkg.sv
// md5_crack_pkg: detector state encoding and default widths/latency
//  IDLE/RUN/FOUND/DONE states; DEF_* defaults for the md5_match_detector parameters.
package md5_crack_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FOUND, DONE} state_t;
  localparam int DEF_PIPE_LATENCY = 64;
  localparam int DEF_GUESS_W = 128;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 48;
endpackage

// File: rtl/guess_delay_line.sv
// guess_delay_line: W-bit, D-stage shift register with async reset and synchronous flush
//  clk, reset (async, active-high), flush (sync clear of every stage), d (head input), q (tail, d delayed D cycles)
module guess_delay_line #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s [D];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < D; i++) s[i] <= '0;
    else if (flush)
      for (int i = 0; i < D; i++) s[i] <= '0;
    else begin
      s[0] <= d;
      for (int i = 1; i < D; i++) s[i] <= s[i-1];
    end
  assign q = s[D-1];
endmodule

// File: rtl/md5_match_detector.sv
// md5_match_detector: tracks guesses through the MD5 pipeline latency and reports the first digest match
//  clk, reset (async, active-high); start latches target_a..d and (re)enters RUN
//  in_valid/in_guess/in_guesslen/in_last: guess entering the MD5 pipeline this cycle
//  hashA..hashD: free-running digest words, aligned with the delay-line tail
//  halt = not RUN; found/done sticky; found_guess/found_len capture; tested_cnt counts compared tails
module md5_match_detector
  import md5_crack_pkg::*;
#(
  parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int GUESS_W = DEF_GUESS_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        target_a,
  input  logic [31:0]        target_b,
  input  logic [31:0]        target_c,
  input  logic [31:0]        target_d,
  input  logic               in_valid,
  input  logic [GUESS_W-1:0] in_guess,
  input  logic [LEN_W-1:0]   in_guesslen,
  input  logic               in_last,
  input  logic [31:0]        hashA,
  input  logic [31:0]        hashB,
  input  logic [31:0]        hashC,
  input  logic [31:0]        hashD,
  output logic               halt,
  output logic               found,
  output logic               done,
  output logic [GUESS_W-1:0] found_guess,
  output logic [LEN_W-1:0]   found_len,
  output logic [CNT_W-1:0]   tested_cnt
);
  localparam int W = GUESS_W + LEN_W + 2;
  state_t state, state_n;
  logic [127:0] target;
  logic [W-1:0] tail;
  logic t_valid, t_last, cmp, match;
  logic [GUESS_W-1:0] t_guess;
  logic [LEN_W-1:0] t_len;
  // start flushes the line so guesses from an earlier search never reach the comparator
  guess_delay_line #(.W(W), .D(PIPE_LATENCY)) u_dl (
    .clk,
    .reset,
    .flush(start),
    .d({in_valid && state == RUN, in_last, in_guess, in_guesslen}),
    .q(tail)
  );
  assign {t_valid, t_last, t_guess, t_len} = tail;
  // start beats a coincident tail: nothing is compared, counted or captured that cycle
  assign cmp = t_valid && state == RUN && !start;
  assign match = cmp && {hashA, hashB, hashC, hashD} == target;
  assign halt = state != RUN;
  always_comb state_n = start ? RUN : match ? FOUND : (cmp && t_last) ? DONE : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      target <= '0;
      found <= 1'b0;
      done <= 1'b0;
      found_guess <= '0;
      found_len <= '0;
      tested_cnt <= '0;
    end else if (start) begin
      target <= {target_a, target_b, target_c, target_d};
      found <= 1'b0;
      done <= 1'b0;
      found_guess <= '0;
      found_len <= '0;
      tested_cnt <= '0;
    end else begin
      if (cmp) tested_cnt <= tested_cnt + {{(CNT_W-1){1'b0}}, ~&tested_cnt};
      if (match) begin
        found <= 1'b1;
        done <= 1'b1;
        found_guess <= t_guess;
        found_len <= t_len;
      end else if (cmp && t_last) done <= 1'b1;
    end
endmodule

// File: tb/tb_md5_match_detector.sv
// tb_md5_match_detector: randomized and directed checks of md5_match_detector against a search-rule model
module tb_md5_match_detector;
  localparam int L = 64;
  localparam logic [127:0] ABC = 128'h616263 << 104;
  localparam logic [127:0] DIG = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
  typedef struct {logic [127:0] g; logic [3:0] l; logic last;} ent_t;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0;
  logic [31:0] target_a = 0, target_b = 0, target_c = 0, target_d = 0;
  logic [127:0] in_guess = 0;
  logic [3:0] in_guesslen = 0;
  logic [31:0] hashA, hashB, hashC, hashD;
  logic halt, found, done;
  logic [127:0] found_guess;
  logic [3:0] found_len;
  logic [47:0] tested_cnt;
  logic [127:0] hp [L];
  logic [127:0] tgt;
  ent_t q[$];
  int vecs = 0, errs = 0;

  md5_match_detector #(.PIPE_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start),
    .target_a(target_a), .target_b(target_b), .target_c(target_c), .target_d(target_d),
    .in_valid(in_valid), .in_guess(in_guess), .in_guesslen(in_guesslen), .in_last(in_last),
    .hashA(hashA), .hashB(hashB), .hashC(hashC), .hashD(hashD),
    .halt(halt), .found(found), .done(done),
    .found_guess(found_guess), .found_len(found_len), .tested_cnt(tested_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] md5_lut(input logic [127:0] g);
    return g == ABC ? DIG : ({g[63:0], g[127:64]} ^ 128'hc3c3c3c3_5a5a5a5a_0f0f0f0f_a5a5a5a5);
  endfunction

  always @(posedge clk) begin
    hp[0] <= md5_lut(in_guess);
    for (int i = 1; i < L; i++) hp[i] <= hp[i-1];
  end
  assign {hashA, hashB, hashC, hashD} = hp[L-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input logic [127:0] t);
    {target_a, target_b, target_c, target_d} = t;
    tgt = t;
    q.delete();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic issue(input logic [127:0] g, input logic [3:0] l, input logic last);
    in_valid = 1;
    in_guess = g;
    in_guesslen = l;
    in_last = last;
    q.push_back('{g, l, last});
    tick();
    in_valid = 0;
    in_last = 0;
  endtask

  function automatic logic [127:0] rnd_guess();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model(output logic ef, output logic ed, output logic [127:0] eg, output logic [3:0] el, output int ec);
    ef = 0; ed = 0; eg = 0; el = 0; ec = 0;
    for (int i = 0; i < q.size(); i++) begin
      ec++;
      if (md5_lut(q[i].g) == tgt) begin
        ef = 1; ed = 1; eg = q[i].g; el = q[i].l;
        break;
      end
      if (q[i].last) begin
        ed = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    vecs++; if (halt !== 1'b1) begin errs++; $display("FAIL reset_halt got %0b exp 1", halt); end
    vecs++; if (found !== 1'b0) begin errs++; $display("FAIL reset_found got %0b exp 0", found); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %0b exp 0", done); end
    vecs++; if (tested_cnt !== 48'd0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", tested_cnt); end
    vecs++; if (found_guess !== 128'd0 || found_len !== 4'd0) begin errs++; $display("FAIL reset_capture got %0h/%0d exp 0/0", found_guess, found_len); end
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_abc();
    do_start(DIG);
    vecs++; if (halt !== 1'b0) begin errs++; $display("FAIL abc_halt_after_start got %0b exp 0", halt); end
    issue(ABC, 4'd3, 1'b0);
    ticks(L - 1);
    vecs++; if (found !== 1'b0) begin errs++; $display("FAIL abc_found_early got %0b exp 0", found); end
    tick();
    vecs++; if (found !== 1'b1 || done !== 1'b1) begin errs++; $display("FAIL abc_found_done got %0b/%0b exp 1/1", found, done); end
    vecs++; if (found_guess !== ABC) begin errs++; $display("FAIL abc_guess got %0h exp %0h", found_guess, ABC); end
    vecs++; if (found_len !== 4'd3) begin errs++; $display("FAIL abc_len got %0d exp 3", found_len); end
    vecs++; if (tested_cnt !== 48'd1) begin errs++; $display("FAIL abc_cnt got %0d exp 1", tested_cnt); end
    vecs++; if (halt !== 1'b1) begin errs++; $display("FAIL abc_halt got %0b exp 1", halt); end
  endtask

  task automatic test_drain();
    do_start(DIG);
    for (int i = 0; i < 10; i++) issue(rnd_guess(), 4'($urandom_range(1, 15)), i == 9);
    ticks(L + 2);
    vecs++; if (done !== 1'b1 || found !== 1'b0) begin errs++; $display("FAIL drain_done_found got %0b/%0b exp 1/0", done, found); end
    vecs++; if (tested_cnt !== 48'd10) begin errs++; $display("FAIL drain_cnt got %0d exp 10", tested_cnt); end
    vecs++; if (halt !== 1'b1) begin errs++; $display("FAIL drain_halt got %0b exp 1", halt); end
  endtask

  task automatic test_first_match();
    do_start(DIG);
    for (int i = 1; i <= 9; i++)
      issue(i == 3 ? ABC : i == 5 ? ABC : rnd_guess(), i == 5 ? 4'd7 : i == 3 ? 4'd3 : 4'd9, i == 9);
    ticks(L + 2);
    vecs++; if (found !== 1'b1 || found_len !== 4'd3) begin errs++; $display("FAIL first_match got found %0b len %0d exp 1/3", found, found_len); end
    vecs++; if (tested_cnt !== 48'd3) begin errs++; $display("FAIL first_match_cnt got %0d exp 3", tested_cnt); end
  endtask

  task automatic test_reset_mid_run();
    do_start(DIG);
    for (int i = 0; i < 5; i++) issue(rnd_guess(), 4'd4, 1'b0);
    ticks(L);
    vecs++; if (tested_cnt !== 48'd5) begin errs++; $display("FAIL midrun_pre_cnt got %0d exp 5", tested_cnt); end
    for (int i = 0; i < 20; i++) issue(i == 10 ? ABC : rnd_guess(), 4'd3, 1'b0);
    #2;
    reset = 1;
    #1;
    vecs++; if (tested_cnt !== 48'd0 || halt !== 1'b1) begin errs++; $display("FAIL midrun_async got cnt %0d halt %0b exp 0/1", tested_cnt, halt); end
    tick();
    reset = 0;
    ticks(L + 5);
    vecs++; if (tested_cnt !== 48'd0 || found !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL midrun_after got cnt %0d found %0b done %0b exp 0/0/0", tested_cnt, found, done); end
    vecs++; if (halt !== 1'b1) begin errs++; $display("FAIL midrun_halt got %0b exp 1", halt); end
  endtask

  task automatic test_start_vs_match();
    do_start(DIG);
    issue(ABC, 4'd3, 1'b0);
    ticks(L - 1);
    do_start(DIG);
    vecs++; if (found !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL collide_found_done got %0b/%0b exp 0/0", found, done); end
    vecs++; if (tested_cnt !== 48'd0 || halt !== 1'b0) begin errs++; $display("FAIL collide_cnt_halt got %0d/%0b exp 0/0", tested_cnt, halt); end
    issue(ABC, 4'd5, 1'b1);
    ticks(L + 2);
    vecs++; if (found !== 1'b1 || found_len !== 4'd5 || tested_cnt !== 48'd1) begin errs++; $display("FAIL collide_rerun got found %0b len %0d cnt %0d exp 1/5/1", found, found_len, tested_cnt); end
  endtask

  task automatic test_idle_ignored();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 5; i++) issue(ABC, 4'd3, 1'b0);
    do_start(DIG);
    ticks(L + 5);
    vecs++; if (tested_cnt !== 48'd0 || found !== 1'b0) begin errs++; $display("FAIL idle_ignored got cnt %0d found %0b exp 0/0", tested_cnt, found); end
    vecs++; if (halt !== 1'b0) begin errs++; $display("FAIL idle_halt got %0b exp 0", halt); end
  endtask

  task automatic test_random();
    logic ef, ed;
    logic [127:0] eg;
    logic [3:0] el;
    int ec, n;
    for (int r = 0; r < 8; r++) begin
      do_start(DIG);
      n = $urandom_range(5, 40);
      for (int i = 0; i < n; i++) begin
        ticks($urandom_range(0, 2));
        issue($urandom_range(0, 7) == 0 ? ABC : rnd_guess(), 4'($urandom_range(1, 15)), i == n - 1 && $urandom_range(0, 1) == 1);
      end
      ticks(L + 2);
      model(ef, ed, eg, el, ec);
      vecs++; if (found !== ef || done !== ed) begin errs++; $display("FAIL rnd%0d_found_done got %0b/%0b exp %0b/%0b", r, found, done, ef, ed); end
      vecs++; if (tested_cnt !== 48'(ec)) begin errs++; $display("FAIL rnd%0d_cnt got %0d exp %0d", r, tested_cnt, ec); end
      vecs++; if (found_guess !== eg || found_len !== el) begin errs++; $display("FAIL rnd%0d_capture got %0h/%0d exp %0h/%0d", r, found_guess, found_len, eg, el); end
      vecs++; if (halt !== ed) begin errs++; $display("FAIL rnd%0d_halt got %0b exp %0b", r, halt, ed); end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_drain();
    test_first_match();
    test_reset_mid_run();
    test_start_vs_match();
    test_idle_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
